// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo
// Receives an 8N1 UART stream (LSB first, fixed baud) and queues the bytes
// in a show-ahead FIFO. A valid/ready interface drains the FIFO.
//
// Optional feature macro: UART_RX_PARITY_EN adds an even-parity bit after
// the data bits and a sticky parity_err_o output.
//
// Ports:
//   clk          system clock, rising edge
//   rst          synchronous active-high reset
//   uart_rx_i    asynchronous serial input, idles high
//   m_data_o     byte at FIFO head (meaningful only while m_valid_o=1)
//   m_valid_o    FIFO non-empty
//   m_ready_i    consumer accepts the head byte when m_valid_o=1
//   level_o      FIFO occupancy, 0..FIFO_DEPTH
//   overflow_o   sticky: a received byte was dropped because the FIFO was full
//   frame_err_o  sticky: a stop bit was sampled low
//   parity_err_o sticky: parity mismatch (UART_RX_PARITY_EN only)
//   clr_err_i    pulse clearing the sticky flags; a coincident error wins
module uart_rx_fifo #(
    parameter int CLKS_PER_BIT = 434,
    parameter int FIFO_DEPTH   = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          uart_rx_i,
    output logic [7:0]                    m_data_o,
    output logic                          m_valid_o,
    input  logic                          m_ready_i,
    output logic [$clog2(FIFO_DEPTH):0]   level_o,
    output logic                          overflow_o,
    output logic                          frame_err_o,
`ifdef UART_RX_PARITY_EN
    output logic                          parity_err_o,
`endif
    input  logic                          clr_err_i
);

    localparam int          PTR_W     = $clog2(FIFO_DEPTH);
    localparam logic [15:0] HALF_LOAD = 16'(CLKS_PER_BIT / 2 - 1);
    localparam logic [15:0] FULL_LOAD = 16'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
`ifdef UART_RX_PARITY_EN
        ST_PARITY,
`endif
        ST_STOP,
        ST_WAIT_HIGH
    } state_t;

    // ---------------- input synchronizer ----------------
    logic rx_meta_reg, rx_s_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta_reg <= 1'b1;
            rx_s_reg    <= 1'b1;
        end else begin
            rx_meta_reg <= uart_rx_i;
            rx_s_reg    <= rx_meta_reg;
        end
    end

    // ---------------- receive FSM ----------------
    state_t      state_reg, state_next;
    logic [15:0] baud_reg, baud_next;
    logic [2:0]  bit_idx_reg, bit_idx_next;
    logic [7:0]  shift_reg, shift_next;
    logic        push;
    logic        frame_set;
`ifdef UART_RX_PARITY_EN
    logic        parity_bad_reg, parity_bad_next;
    logic        parity_set;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= ST_IDLE;
            baud_reg    <= '0;
            bit_idx_reg <= '0;
            shift_reg   <= '0;
`ifdef UART_RX_PARITY_EN
            parity_bad_reg <= 1'b0;
`endif
        end else begin
            state_reg   <= state_next;
            baud_reg    <= baud_next;
            bit_idx_reg <= bit_idx_next;
            shift_reg   <= shift_next;
`ifdef UART_RX_PARITY_EN
            parity_bad_reg <= parity_bad_next;
`endif
        end
    end

    always_comb begin
        state_next   = state_reg;
        baud_next    = baud_reg;
        bit_idx_next = bit_idx_reg;
        shift_next   = shift_reg;
        push         = 1'b0;
        frame_set    = 1'b0;
`ifdef UART_RX_PARITY_EN
        parity_bad_next = parity_bad_reg;
        parity_set      = 1'b0;
`endif
        // Every timed state counts down and acts on the cycle the counter is 0.
        if (state_reg != ST_IDLE && state_reg != ST_WAIT_HIGH && baud_reg != 16'd0)
            baud_next = baud_reg - 16'd1;

        case (state_reg)
            ST_IDLE: begin
                if (!rx_s_reg) begin
                    baud_next  = HALF_LOAD;
                    state_next = ST_START;
                end
            end
            ST_START: begin
                if (baud_reg == 16'd0) begin
                    if (!rx_s_reg) begin
                        baud_next    = FULL_LOAD;
                        bit_idx_next = 3'd0;
                        state_next   = ST_DATA;
                    end else begin
                        // Start bit vanished by mid-bit: treat it as a glitch.
                        state_next = ST_IDLE;
                    end
                end
            end
            ST_DATA: begin
                if (baud_reg == 16'd0) begin
                    shift_next   = {rx_s_reg, shift_reg[7:1]};
                    baud_next    = FULL_LOAD;
                    bit_idx_next = bit_idx_reg + 3'd1;
                    if (bit_idx_reg == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        state_next = ST_PARITY;
`else
                        state_next = ST_STOP;
`endif
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            ST_PARITY: begin
                if (baud_reg == 16'd0) begin
                    // Even parity: the parity bit equals the XOR of the data bits.
                    parity_bad_next = (rx_s_reg != ^shift_reg);
                    parity_set      = (rx_s_reg != ^shift_reg);
                    baud_next       = FULL_LOAD;
                    state_next      = ST_STOP;
                end
            end
`endif
            ST_STOP: begin
                if (baud_reg == 16'd0) begin
                    if (rx_s_reg) begin
`ifdef UART_RX_PARITY_EN
                        push = !parity_bad_reg;
`else
                        push = 1'b1;
`endif
                        state_next = ST_IDLE;
                    end else begin
                        frame_set  = 1'b1;
                        state_next = ST_WAIT_HIGH;
                    end
                end
            end
            ST_WAIT_HIGH: begin
                // Hold off until the line returns high so a break counts once.
                if (rx_s_reg)
                    state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // ---------------- FIFO ----------------
    logic [7:0]     mem [FIFO_DEPTH];
    logic [PTR_W:0] wr_ptr_reg, rd_ptr_reg, rd_ptr_next;
    logic [7:0]     m_data_reg;
    logic           overflow_reg, frame_err_reg;
    logic           pop, full, wr_en, ovf_set;

    assign level_o     = wr_ptr_reg - rd_ptr_reg;
    assign m_valid_o   = (wr_ptr_reg != rd_ptr_reg);
    assign full        = (level_o == (PTR_W + 1)'(FIFO_DEPTH));
    assign pop         = m_valid_o && m_ready_i;
    // A simultaneous pop frees the slot, so a push into a full FIFO is legal then.
    assign wr_en       = push && (!full || pop);
    assign ovf_set     = push && full && !pop;
    assign rd_ptr_next = rd_ptr_reg + {{PTR_W{1'b0}}, pop};

    always_ff @(posedge clk) begin
        if (wr_en)
            mem[wr_ptr_reg[PTR_W-1:0]] <= shift_reg;
    end

    // Registered show-ahead read: prefetch the next head, bypassing the
    // byte being written when it becomes the head on this edge.
    always_ff @(posedge clk) begin
        if (rst)
            m_data_reg <= '0;
        else if (wr_en && (wr_ptr_reg[PTR_W-1:0] == rd_ptr_next[PTR_W-1:0]))
            m_data_reg <= shift_reg;
        else
            m_data_reg <= mem[rd_ptr_next[PTR_W-1:0]];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg    <= '0;
            rd_ptr_reg    <= '0;
            overflow_reg  <= 1'b0;
            frame_err_reg <= 1'b0;
        end else begin
            wr_ptr_reg    <= wr_ptr_reg + {{PTR_W{1'b0}}, wr_en};
            rd_ptr_reg    <= rd_ptr_next;
            overflow_reg  <= ovf_set   | (overflow_reg  & ~clr_err_i);
            frame_err_reg <= frame_set | (frame_err_reg & ~clr_err_i);
        end
    end

`ifdef UART_RX_PARITY_EN
    logic parity_err_reg;

    always_ff @(posedge clk) begin
        if (rst)
            parity_err_reg <= 1'b0;
        else
            parity_err_reg <= parity_set | (parity_err_reg & ~clr_err_i);
    end

    assign parity_err_o = parity_err_reg;
`endif

    assign m_data_o    = m_data_reg;
    assign overflow_o  = overflow_reg;
    assign frame_err_o = frame_err_reg;

endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
- Receives the PULPino `uart_tx` serial stream: 8N1, LSB first, fixed baud.
- Stores received bytes in a small synchronous FIFO.
- The CW305 host-side logic pulls bytes through a valid/ready interface.
- Sits directly downstream of the PULPino core's UART output, on the same system clock.

Parameters:
- CLKS_PER_BIT, 434, clock cycles per UART bit (50 MHz / 115200); legal range 4..65535.
- FIFO_DEPTH, 16, byte entries; power of two, 2..256.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, synchronous, active-high.
- uart_rx_i  in  1  serial line from the core's uart_tx; asynchronous, idles high.
- m_data_o  out  8  byte at FIFO head.
- m_valid_o  out  1  FIFO non-empty.
- m_ready_i  in  1  consumer accepts m_data_o when m_valid_o is high.
- level_o  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.
- overflow_o  out  1  sticky: a byte was dropped because the FIFO was full.
- frame_err_o  out  1  sticky: a stop bit was sampled low.
- clr_err_i  in  1  one-cycle pulse; clears overflow_o and frame_err_o.

Behaviour:
- Reset values:
  - State IDLE; bit counter and baud counter 0.
  - Synchronizer flops 1; FIFO pointers 0.
  - m_valid_o=0, m_data_o=0, level_o=0, overflow_o=0, frame_err_o=0.
- Input synchronizer: uart_rx_i passes through 2 flops (rx_s). All decisions use rx_s, adding 2 cycles of latency.
- IDLE:
  - On rx_s==0, load baud counter with CLKS_PER_BIT/2-1 (integer divide) and go to START.
- START:
  - When baud counter reaches 0, sample rx_s.
  - If 0: load CLKS_PER_BIT-1, clear bit index, go to DATA.
  - If 1: treat as a glitch and return to IDLE.
- DATA:
  - Each time the counter reaches 0, shift rx_s into bit[index] (LSB first) and reload CLKS_PER_BIT-1.
  - After index 7, go to STOP (or PARITY if enabled).
- STOP: when the counter reaches 0, sample rx_s.
  - If 1: push the byte and go to IDLE.
  - If 0: set frame_err_o, discard the byte, go to WAIT_HIGH.
- WAIT_HIGH: stay until rx_s==1, then go to IDLE. A held-low line (break) yields exactly one frame error.
- FIFO: show-ahead.
  - m_data_o reflects the head whenever m_valid_o=1; m_data_o is don't-care when empty.
  - A pushed byte into an empty FIFO makes m_valid_o=1 on the cycle after the push.
  - Pop occurs when m_valid_o && m_ready_i.
- Full boundary:
  - Push while full with no pop: byte dropped, overflow_o set, contents unchanged.
  - Push and pop in the same cycle while full: both take effect; level unchanged; no overflow.
- Empty boundary: m_ready_i while empty has no effect. level_o never underflows or exceeds FIFO_DEPTH.
- Pointer wrap-around uses an extra MSB for full/empty distinction.
- Sticky flags:
  - clr_err_i clears both flags.
  - If clr_err_i coincides with a new error event, the set wins and the flag stays 1.
- Reset mid-frame: a partial byte is discarded and the FSM returns to IDLE. A line still low after reset starts a new START check; a glitch is rejected per the START rule.
- End-to-end latency: m_valid_o asserts 2 + CLKS_PER_BIT/2 + 9*CLKS_PER_BIT + 1 cycles after the start-bit falling edge (±1 for synchronizer phase), when the FIFO was empty.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- Defined:
  - Adds output port parity_err_o (1 bit, sticky, reset 0, cleared by clr_err_i, set-wins).
  - Adds a PARITY state after DATA: sample one bit and compare with even parity of the 8 data bits.
  - On mismatch: set parity_err_o and discard the byte. The stop bit is still checked; a low stop bit also sets frame_err_o.
- Not defined: no PARITY state and no parity_err_o port; the frame is strictly 8N1.

Test Plan (CLKS_PER_BIT=8, FIFO_DEPTH=4):
- Single frame:
  - Stimulus: send 0xA5 (8N1) on an idle line, m_ready_i=0.
  - Response: m_valid_o=1, m_data_o=0xA5, level_o=1; no error flags.
  - Then pulse m_ready_i: m_valid_o=0, level_o=0.
- Overflow:
  - Stimulus: send 0x01..0x05 back-to-back with m_ready_i=0.
  - Response: level_o=4, overflow_o=1. Pops return 0x01,0x02,0x03,0x04; 0x05 is lost.
  - Then clr_err_i: overflow_o=0.
- Full with simultaneous pop:
  - Stimulus: with 4 bytes stored, hold m_ready_i=1 in the cycle the 5th byte 0x77 is pushed.
  - Response: no overflow, level_o stays 4, 0x77 is the last byte read.
- Glitch rejection:
  - Stimulus: drive uart_rx_i low for 2 cycles, then high.
  - Response: FSM returns to IDLE, level_o=0, frame_err_o=0.
- Framing error:
  - Stimulus: send 0x3C with the stop bit low, holding low 20 cycles, then send 0x42 normally.
  - Response: frame_err_o=1; 0x3C not stored; 0x42 received correctly with level_o=1.
- Reset mid-frame:
  - Stimulus: assert rst for 1 cycle during data bit 4 of 0xFF, then let the line idle.
  - Response: all outputs return to reset values and no byte is stored.
  - A subsequent 0x5A is received correctly.
